// File: rtl/mux_src_arbiter.sv
// Two-source round-robin arbiter with a burst cap, steering the shared registered
// 2:1 operand mux into a single output slot with a valid/ready handshake.
module mux_src_arbiter #(
  parameter int DATA_W = 32,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);

  localparam logic [3:0] BURST_CAP = 4'(BURST);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slotState_t;

  slotState_t        r_state;
  slotState_t        w_nextState;
  logic              r_last;
  logic [3:0]        r_run;
  logic [DATA_W-1:0] r_data;
  logic              r_src;

  logic              w_slotFree;
  logic              w_accept;
  logic              w_winner;
  logic [3:0]        w_runNext;

  // Arbitration: the previous winner keeps the slot only while its run is under
  // the cap and the other side is also asking; a lone requester always wins.
  always_comb begin
    w_nextState = r_state;
    w_slotFree  = (r_state == S_EMPTY) || out_ready;
    w_accept    = w_slotFree && (req0 || req1);
    w_winner    = req1;
    w_runNext   = r_run;

    if (req0 && req1) begin
      w_winner = (r_run < BURST_CAP) ? r_last : !r_last;
    end

    if (w_winner == r_last) begin
      w_runNext = (r_run >= BURST_CAP) ? BURST_CAP : r_run + 4'd1;
    end else begin
      w_runNext = 4'd1;
    end

    if (w_accept) begin
      w_nextState = S_FULL;
    end else if ((r_state == S_FULL) && out_ready) begin
      w_nextState = S_EMPTY;
    end

    gnt0 = rst_n && w_accept && !w_winner;
    gnt1 = rst_n && w_accept && w_winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Word, source tag and fairness history only move when a word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_src  <= 1'b0;
      r_last <= 1'b0;
      r_run  <= 4'd0;
    end else if (w_accept) begin
      r_data <= w_winner ? data1 : data0;
      r_src  <= w_winner;
      r_last <= w_winner;
      r_run  <= w_runNext;
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Randomized and directed bench for mux_src_arbiter, checked every cycle against
// a grant-history model of the arbitration rules.
module tb_mux_src_arbiter;

  localparam int DATA_W = 32;
  localparam int BURST  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b1;
  logic              req1 = 1'b1;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] data0 = 32'hC0;
  logic [DATA_W-1:0] data1 = 32'hC1;
  logic              gnt0;
  logic              gnt1;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;

  int errors = 0;
  int checks = 0;

  int                hist[$];
  bit                mValid = 1'b0;
  logic [DATA_W-1:0] mData = '0;
  bit                mSrc = 1'b0;
  bit                mGnt0Edge = 1'b0;
  bit                mGnt1Edge = 1'b0;

  mux_src_arbiter #(.DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Length of the trailing run of identical winners in the grant history.
  function automatic int streak();
    int n;
    n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  // Which source the rules say is granted right now (-1 for none).
  function automatic int expWinner();
    int  last;
    bit  slotFree;
    last     = (hist.size() != 0) ? hist[hist.size() - 1] : 0;
    slotFree = !mValid || out_ready;
    if (!rst_n || !slotFree) return -1;
    if (req0 && req1) return (streak() < BURST) ? last : 1 - last;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : modelUpdate
    int w;
    if (!rst_n) begin
      hist.delete();
      mValid    <= 1'b0;
      mData     <= '0;
      mSrc      <= 1'b0;
      mGnt0Edge <= 1'b0;
      mGnt1Edge <= 1'b0;
    end else begin
      w = expWinner();
      mGnt0Edge <= (w == 0);
      mGnt1Edge <= (w == 1);
      if (w >= 0) begin
        hist.push_back(w);
        if (hist.size() > 16) void'(hist.pop_front());
        mValid <= 1'b1;
        mData  <= (w == 1) ? data1 : data0;
        mSrc   <= (w == 1);
      end else if (mValid && out_ready) begin
        mValid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compareProc
    int w;
    w = expWinner();
    checkOutput("gnt0", DATA_W'(gnt0), DATA_W'(w == 0));
    checkOutput("gnt1", DATA_W'(gnt1), DATA_W'(w == 1));
    checkOutput("out_valid", DATA_W'(out_valid), DATA_W'(mValid));
    checkOutput("out_data", out_data, mData);
    checkOutput("out_src", DATA_W'(out_src), DATA_W'(mSrc));
  end

  // Random traffic; a pending, ungranted word keeps its data until granted or withdrawn.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (req0 && !mGnt0Edge) begin
      if ($urandom_range(0, 7) == 0) req0 = 1'b0;
    end else begin
      req0  = ($urandom_range(0, 2) != 0);
      data0 = $urandom;
    end
    if (req1 && !mGnt1Edge) begin
      if ($urandom_range(0, 7) == 0) req1 = 1'b0;
    end else begin
      req1  = ($urandom_range(0, 2) != 0);
      data1 = $urandom;
    end
    out_ready = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 199) == 0) begin
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int expSeq[8];
    expSeq = '{0, 0, 1, 1, 0, 0, 1, 1};

    #3;
    checkOutput("rst gnt0", DATA_W'(gnt0), 32'd0);
    checkOutput("rst gnt1", DATA_W'(gnt1), 32'd0);
    checkOutput("rst out_valid", DATA_W'(out_valid), 32'd0);
    checkOutput("rst out_data", out_data, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("rst held gnt0", DATA_W'(gnt0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post-rst gnt0", DATA_W'(gnt0), 32'd1);
    checkOutput("post-rst gnt1", DATA_W'(gnt1), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("post-rst out_data", out_data, 32'hC0);
    checkOutput("post-rst out_src", DATA_W'(out_src), 32'd0);

    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data0 = 32'h10 + 32'(i);
      #1;
      checkOutput("stream gnt1", DATA_W'(gnt1), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("stream out_data", out_data, 32'h10 + 32'(i));
      checkOutput("stream out_valid", DATA_W'(out_valid), 32'd1);
    end

    req1  = 1'b1;
    data0 = 32'hD0;
    data1 = 32'hD1;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", DATA_W'(out_valid), 32'd0);
    checkOutput("async rst gnt0", DATA_W'(gnt0), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rerst gnt0", DATA_W'(gnt0), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("burst out_src", DATA_W'(out_src), DATA_W'(expSeq[i]));
      checkOutput("burst out_data", out_data, (expSeq[i] == 1) ? 32'hD1 : 32'hD0);
    end

    req1  = 1'b0;
    data0 = 32'hA5;
    @(posedge clk);
    #1;
    checkOutput("bp word", out_data, 32'hA5);
    out_ready = 1'b0;
    data0     = 32'hA6;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp gnt0", DATA_W'(gnt0), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bp hold data", out_data, 32'hA5);
      checkOutput("bp hold valid", DATA_W'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release gnt0", DATA_W'(gnt0), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp next word", out_data, 32'hA6);

    req0  = 1'b0;
    req1  = 1'b1;
    data1 = 32'h5A;
    @(posedge clk);
    #1;
    checkOutput("drain word", out_data, 32'h5A);
    checkOutput("drain src", DATA_W'(out_src), 32'd1);
    req1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drain valid", DATA_W'(out_valid), 32'd0);
    checkOutput("drain hold data", out_data, 32'h5A);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
    end

    @(posedge clk);
    #1;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
